// File: rtl/direction_uart_tx.sv
// direction_uart_tx
// Turns per-line orange-object direction results into single-byte UART
// commands. The result sampled at each HREF falling edge goes through a
// stability filter. A command is committed only after STABLE_LINES identical
// line results, and only if it differs from the last committed command.
// Committed commands are serialised on tx (8N1, LSB first).
// Optional build macro: DIR_TX_PARITY_EN adds an even-parity bit (8E1 frame).
module direction_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int STABLE_LINES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       HREF,
    input  logic       orangeDetected,
    input  logic [2:0] direction,
    output logic       tx,
    output logic       busy,
    output logic       cmd_sent,
    output logic [7:0] last_cmd
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CNT_W  = $clog2(STABLE_LINES + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  STABLE_CNT = CNT_W'(STABLE_LINES);

    localparam logic [7:0] CMD_LEFT   = 8'h4C;
    localparam logic [7:0] CMD_RIGHT  = 8'h52;
    localparam logic [7:0] CMD_CENTRE = 8'h46;
    localparam logic [7:0] CMD_STOP   = 8'h53;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef DIR_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    logic             href_q;
    logic             href_fall;
    logic [7:0]       sample;
    logic [7:0]       candidate;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] next_count;
    logic             same;
    logic             sat_hold;
    logic             commit;

    logic [2:0]        state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_idx;
    logic [2:0]        next_idx;
    logic [7:0]        shreg;
    logic              pend_valid;
    logic [7:0]        pend_byte;
    logic              bit_end;

    assign href_fall = href_q & ~HREF;
    assign bit_end   = (baud_cnt == BAUD_LAST);
    assign next_idx  = bit_idx + 3'd1;
    assign busy      = (state != S_IDLE);
    assign cmd_sent  = (state == S_STOP) && bit_end;

    // Map the classifier outputs to a command byte
    always_comb begin
        sample = CMD_STOP;
        if (orangeDetected) begin
            case (direction)
                3'b001:  sample = CMD_LEFT;
                3'b010:  sample = CMD_RIGHT;
                3'b011:  sample = CMD_CENTRE;
                default: sample = CMD_STOP;
            endcase
        end
    end

    // Stability filter next-state and commit decision
    always_comb begin
        same       = (sample == candidate);
        sat_hold   = same && (count == STABLE_CNT);
        next_count = CNT_W'(1);
        if (same) begin
            next_count = sat_hold ? count : count + CNT_W'(1);
        end
        // Commit only on the sample that brings the count up to the threshold;
        // a count already held at saturation never commits again.
        commit = href_fall && (next_count == STABLE_CNT) && !sat_hold &&
                 (sample != last_cmd);
    end

    // HREF edge register, filter state and committed command
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            href_q    <= 1'b0;
            candidate <= CMD_STOP;
            count     <= '0;
            last_cmd  <= CMD_STOP;
        end else begin
            href_q <= HREF;
            if (href_fall) begin
                candidate <= sample;
                count     <= next_count;
            end
            if (commit) begin
                last_cmd <= sample;
            end
        end
    end

    // UART transmit FSM with single-entry, latest-wins pending slot
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            pend_valid <= 1'b0;
            pend_byte  <= '0;
            tx         <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    tx       <= 1'b1;
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    if (commit) begin
                        shreg      <= sample;
                        pend_valid <= 1'b0;
                        state      <= S_START;
                        tx         <= 1'b0;
                    end else if (pend_valid) begin
                        shreg      <= pend_byte;
                        pend_valid <= 1'b0;
                        state      <= S_START;
                        tx         <= 1'b0;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= S_DATA;
                        tx       <= shreg[0];
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= next_idx;
                        if (bit_idx == 3'd7) begin
`ifdef DIR_TX_PARITY_EN
                            state <= S_PARITY;
                            tx    <= ^shreg;
`else
                            state <= S_STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            tx <= shreg[next_idx];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
`ifdef DIR_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        state    <= S_STOP;
                        tx       <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        state    <= S_IDLE;
                        tx       <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    baud_cnt <= '0;
                    tx       <= 1'b1;
                end
            endcase
            // Commits arriving mid-frame wait in the pending slot
            if (state != S_IDLE && commit) begin
                pend_byte  <= sample;
                pend_valid <= 1'b1;
            end
        end
    end

endmodule
